irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt sources (TC instances, other devices) and CP0.
- Latches and masks source requests, then arbitrates them by fixed priority.
- Presents one interrupt at a time to CP0 and tracks the in-service source until the handler writes end-of-interrupt (EOI).
- Sits on the system bridge beside the timers; accessed through the bridge with the same word-addressed Addr/WE/Din/Dout bus.

Parameters:
- N, 6: number of interrupt sources (1..8); maps onto CP0 HWInt[N+1:2].

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; active when 0.
- Addr  input  30  word address [31:2]; only Addr[3:2] decoded.
- WE  input  1  write enable from bridge (already qualified by address decode).
- Din  input  32  write data.
- Dout  output  32  read data; combinational on Addr[3:2].
- Src  input  N  raw interrupt lines (e.g. TC IRQ), synchronous to clk.
- IntAck  input  1  one-cycle pulse from CP0 when the interrupt exception is taken.
- IntReq  output  1  registered; high while a request is offered to CP0.
- HWInt  output  N  registered one-hot of the offered source; 0 when IntReq=0.

Behaviour:
- Register map, word index Addr[3:2]:
  - 0 MASK (N bits, 1 = enabled, R/W).
  - 1 PEND (N bits; read; write-1-to-clear).
  - 2 MODE (N bits, 1 = edge, 0 = level, R/W).
  - 3 STAT (read; write = EOI).
- STAT read value: {22'b0, state[1:0] at [9:8], 4'b0, busy at [3], CUR[2:0]}.
- Unused upper bits read 0 and are ignored on write.
- Reset (reset=0, async), all zero: MASK, MODE, PEND, src_q, CUR, IntReq, HWInt; state=IDLE.
- src_q[i] holds Src[i] from the previous posedge.
- Edge mode: on a posedge with Src[i]=1 and src_q[i]=0, PEND[i] is set.
- Level mode: PEND[i] is loaded with Src[i] every cycle; W1C writes have no effect on it.
- Edge set and W1C on the same bit in the same cycle: set wins.
- Eligible vector E = PEND & MASK. Winner = lowest index set in E; index 0 has highest priority.
- State machine, state encoding IDLE=0, REQ=1, SERV=2:
  - IDLE: if E≠0, CUR <= winner and go to REQ.
  - REQ: IntReq=1, HWInt=onehot(CUR).
    - If IntAck=1: go to SERV; clear PEND[CUR] if MODE[CUR]=1.
    - Else if E=0: go to IDLE (request withdrawn).
    - Else if winner≠CUR: CUR <= winner, stay in REQ (retarget before ack).
    - IntAck takes precedence over withdraw/retarget in the same cycle.
  - SERV: busy=1, IntReq=0. No nesting: new requests only accumulate in PEND. A write to index 3 goes to IDLE.
- EOI writes outside SERV are ignored.
- IntReq/HWInt are registered from next-state: they change on the same edge as the state change.
- Latency: edge-mode Src rises before posedge k → PEND=1 after k → state=REQ, IntReq=1 after k+1.
- After EOI at edge m, a still-eligible source raises IntReq after m+1 (one IDLE cycle).
- A CPU write to MASK/MODE applies on that posedge; arbitration in the same cycle uses the old values.
- Reset mid-REQ or mid-SERV: everything returns to the reset values immediately (async), IntReq drops without waiting for clk.

Test Plan:
- Reset and read-back: reset=0 then 1; read idx0..3 → all 0. Write MASK=0x3F, MODE=0x3F; read back 0x3F, 0x3F. IntReq=0.
- Edge latency: MODE=0x3F, MASK=0x3F; pulse Src[2] for one cycle before edge k → PEND=0x04 after k; IntReq=1, HWInt=0x04 after k+1. IntAck pulse → STAT=0x20A, PEND=0x00. EOI write → STAT=0x000, IntReq stays 0.
- Priority and retarget: Src[4] edge → REQ with HWInt=0x10; before ack, Src[1] edge → next cycle HWInt=0x02. Ack → CUR=1. After EOI, IntReq=1 with HWInt=0x10 two edges later.
- Mask and W1C: MASK=0x00, Src[3] edge → PEND=0x08, IntReq stays 0. Write PEND=0x08 → PEND=0x00. Edge on Src[3] in the same cycle as that W1C → PEND stays 0x08.
- Level mode, TC-style: MODE[0]=0, MASK[0]=1, Src[0] held high → REQ. Drop Src[0] before ack → PEND[0]=0, state IDLE, IntReq=0 one edge later.
- Async reset during SERV: reset=0 between edges → IntReq, HWInt, STAT, PEND all 0 before the next posedge. EOI write with reset=1 while IDLE → no state change.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Word-addressed register bus between the system bridge and irq_ctrl.
// Addr carries byte-address bits [31:2]; only Addr[3:2] selects a register.
interface irq_ctrl_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks N sources, fixed-priority arbitration (index 0 wins),
// offers one request at a time to CP0 and holds it in service until an EOI write.
module irq_ctrl #(
    parameter int N = 6
) (
    input  logic             clk,
    input  logic             reset,
    irq_ctrl_if.slave        bus,
    input  logic [N-1:0]     Src,
    input  logic             IntAck,
    output logic             IntReq,
    output logic [N-1:0]     HWInt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    localparam logic [1:0] IDX_MASK = 2'd0;
    localparam logic [1:0] IDX_PEND = 2'd1;
    localparam logic [1:0] IDX_MODE = 2'd2;
    localparam logic [1:0] IDX_STAT = 2'd3;

    state_t         state_q, state_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [N-1:0]   mode_q, mode_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   src_q;
    logic [2:0]     cur_q, cur_d;
    logic           int_req_q, int_req_d;
    logic [N-1:0]   hw_int_q, hw_int_d;

    logic [1:0]     idx;
    logic           wr_mask, wr_pend, wr_mode, wr_eoi;
    logic [N-1:0]   wr_data;
    logic [N-1:0]   eligible;
    logic [N-1:0]   rise;
    logic [N-1:0]   w1c;
    logic [N-1:0]   ack_clr;
    logic [2:0]     winner;
    logic           any_eligible;
    logic           busy;
    logic           unused_bus;

    assign idx     = bus.Addr[3:2];
    assign wr_data = bus.Din[N-1:0];
    assign wr_mask = bus.WE && (idx == IDX_MASK);
    assign wr_pend = bus.WE && (idx == IDX_PEND);
    assign wr_mode = bus.WE && (idx == IDX_MODE);
    assign wr_eoi  = bus.WE && (idx == IDX_STAT);

    assign unused_bus = ^{bus.Addr[31:4], bus.Din[31:N]};

    assign eligible     = pend_q & mask_q;
    assign any_eligible = |eligible;
    assign rise         = Src & ~src_q;
    assign w1c          = wr_pend ? wr_data : '0;
    assign ack_clr      = (state_q == REQ && IntAck) ? (N'(1) << cur_q) : '0;
    assign busy         = (state_q == SERV);

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        winner = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Level sources track the line; edge sources set on a rise, which beats any clear.
    for (genvar gi = 0; gi < N; gi++) begin : g_pend
        assign pend_d[gi] = mode_q[gi]
                          ? (rise[gi] | (pend_q[gi] & ~w1c[gi] & ~ack_clr[gi]))
                          : Src[gi];
    end

    assign mask_d = wr_mask ? wr_data : mask_q;
    assign mode_d = wr_mode ? wr_data : mode_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        unique case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    state_d = REQ;
                    cur_d   = winner;
                end
            end
            REQ: begin
                if (IntAck) begin
                    state_d = SERV;
                end else if (!any_eligible) begin
                    state_d = IDLE;
                    cur_d   = 3'd0;
                end else if (winner != cur_q) begin
                    cur_d   = winner;
                end
            end
            SERV: begin
                if (wr_eoi) begin
                    state_d = IDLE;
                    cur_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cur_d   = 3'd0;
            end
        endcase
        // Outputs follow the next state so they move on the same edge as the FSM.
        int_req_d = (state_d == REQ);
        hw_int_d  = (state_d == REQ) ? (N'(1) << cur_d) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            src_q     <= '0;
            cur_q     <= 3'd0;
            int_req_q <= 1'b0;
            hw_int_q  <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            src_q     <= Src;
            cur_q     <= cur_d;
            int_req_q <= int_req_d;
            hw_int_q  <= hw_int_d;
        end
    end

    assign IntReq = int_req_q;
    assign HWInt  = hw_int_q;

    always_comb begin
        bus.Dout = '0;
        unique case (idx)
            IDX_MASK: bus.Dout[N-1:0] = mask_q;
            IDX_PEND: bus.Dout[N-1:0] = pend_q;
            IDX_MODE: bus.Dout[N-1:0] = mode_q;
            IDX_STAT: bus.Dout = {22'b0, state_q, 4'b0, busy, cur_q};
            default:  bus.Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, async-reset sequence, then random
// traffic checked against a cycle-level behavioural model.
module tb_irq_ctrl;
    localparam int N = 6;
    localparam int NVEC = 29;
    localparam int NRND = 500;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  Src;
    logic          IntAck;
    logic          IntReq;
    logic [N-1:0]  HWInt;

    irq_ctrl_if bus ();

    irq_ctrl #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .Src    (Src),
        .IntAck (IntAck),
        .IntReq (IntReq),
        .HWInt  (HWInt)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Behavioural model: registers as plain bit vectors, state as 0=idle 1=offered 2=in service.
    logic [N-1:0] m_mask, m_mode, m_pend, m_prev;
    int           m_state, m_cur;

    typedef struct {
        logic [N-1:0] src;
        logic         ack;
        logic         we;
        logic [1:0]   idx;
        logic [31:0]  din;
        logic [1:0]   rd_idx;
        logic [31:0]  exp_rd;
        logic         exp_req;
        logic [N-1:0] exp_hw;
    } vec_t;

    vec_t vt [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mask  = '0;
        m_mode  = '0;
        m_pend  = '0;
        m_prev  = '0;
        m_state = 0;
        m_cur   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] src, input logic ack, input logic we,
                              input logic [1:0] idx, input logic [31:0] din);
        logic [N-1:0] e, rise, clr, ackm, kept, nxt;
        int win, ns, nc;
        e = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < N; i++) if (e[i] && win < 0) win = i;
        rise = src & ~m_prev;
        clr  = (we && idx == 2'd1) ? din[N-1:0] : '0;
        ackm = (m_state == 1 && ack) ? (N'(1) << m_cur) : '0;
        kept = (m_pend & ~clr & ~ackm) | rise;
        nxt  = (kept & m_mode) | (src & ~m_mode);
        ns = m_state;
        nc = m_cur;
        if (m_state == 0) begin
            if (win >= 0) begin ns = 1; nc = win; end
        end else if (m_state == 1) begin
            if (ack) ns = 2;
            else if (win < 0) begin ns = 0; nc = 0; end
            else nc = win;
        end else begin
            if (we && idx == 2'd3) begin ns = 0; nc = 0; end
        end
        if (we && idx == 2'd0) m_mask = din[N-1:0];
        if (we && idx == 2'd2) m_mode = din[N-1:0];
        m_pend  = nxt;
        m_prev  = src;
        m_state = ns;
        m_cur   = nc;
    endtask

    task automatic cycle(input logic [N-1:0] src, input logic ack, input logic we,
                         input logic [1:0] idx, input logic [31:0] din);
        Src      = src;
        IntAck   = ack;
        bus.WE   = we;
        bus.Addr = {28'b0, idx};
        bus.Din  = din;
        @(posedge clk);
        model_step(src, ack, we, idx, din);
        #1;
        IntAck = 1'b0;
        bus.WE = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] i, output logic [31:0] v);
        bus.Addr = {28'b0, i};
        #1;
        v = bus.Dout;
    endtask

    task automatic check_model(input string tag);
        logic [31:0]  v;
        logic [N-1:0] eh;
        logic [31:0]  es;
        eh = (m_state == 1) ? (N'(1) << m_cur) : '0;
        es = 32'(m_state * 256 + ((m_state == 2) ? 8 : 0) + m_cur);
        check({tag, " IntReq"}, 32'(IntReq), 32'(m_state == 1));
        check({tag, " HWInt"}, 32'(HWInt), 32'(eh));
        read_reg(2'd0, v); check({tag, " MASK"}, v, 32'(m_mask));
        read_reg(2'd1, v); check({tag, " PEND"}, v, 32'(m_pend));
        read_reg(2'd2, v); check({tag, " MODE"}, v, 32'(m_mode));
        read_reg(2'd3, v); check({tag, " STAT"}, v, es);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  rd;
        logic [N-1:0] rsrc;
        logic         rack, rwe;
        logic [1:0]   ridx;
        logic [31:0]  rdin;

        //                 src    ack  we   idx   din     rd    exp_rd   req  hw
        vt[0]  = '{6'h00, 1'b0, 1'b1, 2'd0, 32'h3F, 2'd0, 32'h03F, 1'b0, 6'h00};
        vt[1]  = '{6'h00, 1'b0, 1'b1, 2'd2, 32'h3F, 2'd2, 32'h03F, 1'b0, 6'h00};
        vt[2]  = '{6'h04, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h004, 1'b0, 6'h00};
        vt[3]  = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h102, 1'b1, 6'h04};
        vt[4]  = '{6'h00, 1'b1, 1'b0, 2'd0, 32'h00, 2'd3, 32'h20A, 1'b0, 6'h00};
        vt[5]  = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h000, 1'b0, 6'h00};
        vt[6]  = '{6'h00, 1'b0, 1'b1, 2'd3, 32'h00, 2'd3, 32'h000, 1'b0, 6'h00};
        vt[7]  = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h000, 1'b0, 6'h00};
        vt[8]  = '{6'h00, 1'b0, 1'b1, 2'd3, 32'hFF, 2'd3, 32'h000, 1'b0, 6'h00};
        vt[9]  = '{6'h10, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h010, 1'b0, 6'h00};
        vt[10] = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h104, 1'b1, 6'h10};
        vt[11] = '{6'h02, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h012, 1'b1, 6'h10};
        vt[12] = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h101, 1'b1, 6'h02};
        vt[13] = '{6'h00, 1'b1, 1'b0, 2'd0, 32'h00, 2'd3, 32'h209, 1'b0, 6'h00};
        vt[14] = '{6'h00, 1'b0, 1'b1, 2'd3, 32'h00, 2'd3, 32'h000, 1'b0, 6'h00};
        vt[15] = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h104, 1'b1, 6'h10};
        vt[16] = '{6'h00, 1'b1, 1'b0, 2'd0, 32'h00, 2'd3, 32'h20C, 1'b0, 6'h00};
        vt[17] = '{6'h00, 1'b0, 1'b1, 2'd3, 32'h00, 2'd1, 32'h000, 1'b0, 6'h00};
        vt[18] = '{6'h00, 1'b0, 1'b1, 2'd0, 32'h00, 2'd0, 32'h000, 1'b0, 6'h00};
        vt[19] = '{6'h08, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h008, 1'b0, 6'h00};
        vt[20] = '{6'h00, 1'b0, 1'b1, 2'd1, 32'h08, 2'd1, 32'h000, 1'b0, 6'h00};
        vt[21] = '{6'h08, 1'b0, 1'b1, 2'd1, 32'h08, 2'd1, 32'h008, 1'b0, 6'h00};
        vt[22] = '{6'h08, 1'b0, 1'b1, 2'd1, 32'h08, 2'd1, 32'h000, 1'b0, 6'h00};
        vt[23] = '{6'h00, 1'b0, 1'b1, 2'd2, 32'h3E, 2'd2, 32'h03E, 1'b0, 6'h00};
        vt[24] = '{6'h00, 1'b0, 1'b1, 2'd0, 32'h01, 2'd0, 32'h001, 1'b0, 6'h00};
        vt[25] = '{6'h01, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h001, 1'b0, 6'h00};
        vt[26] = '{6'h01, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h100, 1'b1, 6'h01};
        vt[27] = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd1, 32'h000, 1'b1, 6'h01};
        vt[28] = '{6'h00, 1'b0, 1'b0, 2'd0, 32'h00, 2'd3, 32'h000, 1'b0, 6'h00};

        reset    = 1'b0;
        Src      = '0;
        IntAck   = 1'b0;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        bus.Din  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check_model("reset");

        for (int i = 0; i < NVEC; i++) begin
            cycle(vt[i].src, vt[i].ack, vt[i].we, vt[i].idx, vt[i].din);
            check($sformatf("vec%0d IntReq", i), 32'(IntReq), 32'(vt[i].exp_req));
            check($sformatf("vec%0d HWInt", i), 32'(HWInt), 32'(vt[i].exp_hw));
            read_reg(vt[i].rd_idx, rd);
            check($sformatf("vec%0d reg%0d", i, vt[i].rd_idx), rd, vt[i].exp_rd);
            $display("vec %0d: reg%0d=0x%0h IntReq=%0b HWInt=0x%0h",
                     i, vt[i].rd_idx, rd, IntReq, HWInt);
        end

        // Async reset while in service: outputs and registers clear before the next edge.
        cycle(6'h00, 1'b0, 1'b1, 2'd0, 32'h3F);
        cycle(6'h00, 1'b0, 1'b1, 2'd2, 32'h3F);
        cycle(6'h20, 1'b0, 1'b0, 2'd0, 32'h00);
        cycle(6'h00, 1'b0, 1'b0, 2'd0, 32'h00);
        cycle(6'h01, 1'b1, 1'b0, 2'd0, 32'h00);
        check_model("pre-reset");
        $display("seq reset-in-serv: STAT before reset expected 0x%0h", m_state * 256 + 8 + m_cur);
        #1;
        reset = 1'b0;
        Src   = '0;
        #1;
        check("async IntReq", 32'(IntReq), 32'h0);
        check("async HWInt", 32'(HWInt), 32'h0);
        read_reg(2'd3, rd); check("async STAT", rd, 32'h0);
        read_reg(2'd1, rd); check("async PEND", rd, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(6'h00, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
        check_model("eoi-idle");
        $display("seq eoi-idle: IntReq=%0b", IntReq);

        // Random traffic; sources toggle occasionally so level inputs stay put for a while.
        rsrc = '0;
        for (int i = 0; i < NRND; i++) begin
            if ($urandom_range(0, 3) == 0) rsrc = rsrc ^ N'($urandom);
            rack = ($urandom_range(0, 3) == 0);
            rwe  = ($urandom_range(0, 4) == 0);
            ridx = 2'($urandom);
            rdin = $urandom;
            cycle(rsrc, rack, rwe, ridx, rdin);
            check_model($sformatf("rnd%0d", i));
            $display("rnd %0d: src=0x%0h ack=%0b we=%0b idx=%0d state=%0d cur=%0d",
                     i, rsrc, rack, rwe, ridx, m_state, m_cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
